// File: rtl/snow64_mem_arbiter_pkg.sv
// Shared types for the icache / LAR-file memory arbiter: FSM states, requester ids, port structs.
package PkgSnow64MemArbiter;

    localparam int ArbAddrWidth = 64;
    localparam int ArbLineWidth = 256;

    typedef enum logic [1:0] {
        StIdle,
        StWaitIcache,
        StWaitData
    } State;

    typedef enum logic {
        ReqIcache,
        ReqData
    } Requester;

    typedef struct packed {
        logic                    req;
        logic [ArbAddrWidth-1:0] addr;
    } PortIn_MemArbiter_Icache;

    // Icache requests ride in this shape too, with we and wdata tied to zero.
    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [ArbAddrWidth-1:0] addr;
        logic [ArbLineWidth-1:0] wdata;
    } PortIn_MemArbiter_Data;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [ArbAddrWidth-1:0] addr;
        logic [ArbLineWidth-1:0] wdata;
    } PortOut_MemArbiter_Mem;

endpackage

// File: rtl/snow64_mem_arbiter_req_latch.sv
// Holds one requester's pulse until the arbiter grants it; presents either the held or the live request.
// Latency: capture on the pulse edge; the live request bypasses the latch in the same cycle.
// Backpressure: none; a pulse while pending or in flight is dropped and flagged.
module snow64_mem_arbiter_req_latch
    import PkgSnow64MemArbiter::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  PortIn_MemArbiter_Data req_in,
    input  logic                  in_flight,
    input  logic                  grant,
    output PortIn_MemArbiter_Data eff
);

    logic                  pending_q;
    PortIn_MemArbiter_Data cap_q;
    logic                  accept;

    assign accept = req_in.req && !pending_q && !in_flight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            cap_q     <= '0;
        end else begin
            // A grant in the same cycle as a fresh pulse consumes it via the bypass.
            if (grant) begin
                pending_q <= 1'b0;
            end else if (accept) begin
                pending_q <= 1'b1;
            end
            if (accept) begin
                cap_q <= req_in;
            end
        end
    end

    // Only consumed while the arbiter is idle, where in_flight is always low.
    assign eff = pending_q ? cap_q : req_in;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(req_in.req && (pending_q || in_flight)))
        else $warning("mem arbiter: request pulse while already pending or in flight, ignored");

endmodule

// File: rtl/snow64_mem_arbiter.sv
// Shares the memory port between icache line fills and LAR-file loads/stores, round-robin.
// Latency: request pulse -> out_mem_req next cycle; in_mem_valid -> owner valid next cycle.
// Backpressure: none; one memory transaction outstanding, other requests wait in their latch.
module snow64_mem_arbiter
    import PkgSnow64MemArbiter::*;
#(
    parameter int WIDTH_ADDR = ArbAddrWidth,
    parameter int WIDTH_LINE = ArbLineWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_icache_req,
    input  logic [WIDTH_ADDR-1:0] in_icache_addr,
    output logic                  out_icache_valid,
    output logic [WIDTH_LINE-1:0] out_icache_data,

    input  logic                  in_data_req,
    input  logic                  in_data_we,
    input  logic [WIDTH_ADDR-1:0] in_data_addr,
    input  logic [WIDTH_LINE-1:0] in_data_wdata,
    output logic                  out_data_valid,
    output logic [WIDTH_LINE-1:0] out_data_rdata,

    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [WIDTH_ADDR-1:0] out_mem_addr,
    output logic [WIDTH_LINE-1:0] out_mem_wdata,
    input  logic                  in_mem_valid,
    input  logic [WIDTH_LINE-1:0] in_mem_rdata
);

    PortIn_MemArbiter_Icache icache_port;
    PortIn_MemArbiter_Data   icache_in;
    PortIn_MemArbiter_Data   data_in;
    PortIn_MemArbiter_Data   icache_eff;
    PortIn_MemArbiter_Data   data_eff;
    PortOut_MemArbiter_Mem   mem_q;

    State     state_q;
    State     state_d;
    Requester last_q;
    logic     grant_i;
    logic     grant_d;
    logic     done_i;
    logic     done_d;

    assign icache_port = '{req: in_icache_req, addr: in_icache_addr};
    assign icache_in   = '{req: icache_port.req, we: 1'b0, addr: icache_port.addr, wdata: '0};
    assign data_in     = '{req: in_data_req, we: in_data_we, addr: in_data_addr, wdata: in_data_wdata};

    snow64_mem_arbiter_req_latch u_icache_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (icache_in),
        .in_flight (state_q == StWaitIcache),
        .grant     (grant_i),
        .eff       (icache_eff)
    );

    snow64_mem_arbiter_req_latch u_data_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (data_in),
        .in_flight (state_q == StWaitData),
        .grant     (grant_d),
        .eff       (data_eff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done_i  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // On a tie the requester that did not win last time goes first.
                if (icache_eff.req && (!data_eff.req || last_q == ReqData)) begin
                    grant_i = 1'b1;
                    state_d = StWaitIcache;
                end else if (data_eff.req) begin
                    grant_d = 1'b1;
                    state_d = StWaitData;
                end
            end
            StWaitIcache: begin
                if (in_mem_valid) begin
                    done_i  = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitData: begin
                if (in_mem_valid) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q           <= ReqData;
            mem_q            <= '0;
            out_icache_valid <= 1'b0;
            out_icache_data  <= '0;
            out_data_valid   <= 1'b0;
            out_data_rdata   <= '0;
        end else begin
            mem_q.req <= grant_i || grant_d;
            if (grant_i) begin
                mem_q.we    <= icache_eff.we;
                mem_q.addr  <= icache_eff.addr;
                mem_q.wdata <= icache_eff.wdata;
                last_q      <= ReqIcache;
            end else if (grant_d) begin
                mem_q.we    <= data_eff.we;
                mem_q.addr  <= data_eff.addr;
                mem_q.wdata <= data_eff.wdata;
                last_q      <= ReqData;
            end

            out_icache_valid <= done_i;
            if (done_i) begin
                out_icache_data <= in_mem_rdata;
            end

            // Write acks carry no line; the last read line stays visible.
            out_data_valid <= done_d;
            if (done_d && !mem_q.we) begin
                out_data_rdata <= in_mem_rdata;
            end
        end
    end

    assign out_mem_req   = mem_q.req;
    assign out_mem_we    = mem_q.we;
    assign out_mem_addr  = mem_q.addr;
    assign out_mem_wdata = mem_q.wdata;

endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// Scoreboard bench for snow64_mem_arbiter: a behavioural memory answers out_mem_req after mem_lat cycles.
module tb_snow64_mem_arbiter;

    localparam int AW = 64;
    localparam int LW = 256;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            cyc;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_icache_req = 1'b0;
    logic [AW-1:0] in_icache_addr = '0;
    logic          out_icache_valid;
    logic [LW-1:0] out_icache_data;
    logic          in_data_req = 1'b0;
    logic          in_data_we = 1'b0;
    logic [AW-1:0] in_data_addr = '0;
    logic [LW-1:0] in_data_wdata = '0;
    logic          out_data_valid;
    logic [LW-1:0] out_data_rdata;
    logic          out_mem_req;
    logic          out_mem_we;
    logic [AW-1:0] out_mem_addr;
    logic [LW-1:0] out_mem_wdata;
    logic          in_mem_valid;
    logic [LW-1:0] in_mem_rdata;

    snow64_mem_arbiter #(.WIDTH_ADDR(AW), .WIDTH_LINE(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_icache_req    (in_icache_req),
        .in_icache_addr   (in_icache_addr),
        .out_icache_valid (out_icache_valid),
        .out_icache_data  (out_icache_data),
        .in_data_req      (in_data_req),
        .in_data_we       (in_data_we),
        .in_data_addr     (in_data_addr),
        .in_data_wdata    (in_data_wdata),
        .out_data_valid   (out_data_valid),
        .out_data_rdata   (out_data_rdata),
        .out_mem_req      (out_mem_req),
        .out_mem_we       (out_mem_we),
        .out_mem_addr     (out_mem_addr),
        .out_mem_wdata    (out_mem_wdata),
        .in_mem_valid     (in_mem_valid),
        .in_mem_rdata     (in_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_txn_t      exp_mem[$];
    logic [LW-1:0] exp_ic[$];
    logic [LW-1:0] exp_dt[$];
    logic [LW-1:0] mem[logic [AW-1:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 2;
    int last_done = -100;
    int txn_cnt = 0;
    int stray_req = 0;
    bit rsp_busy = 1'b0;

    localparam logic [LW-1:0] LINE_AA   = {64{4'hA}};
    localparam logic [LW-1:0] LINE_55   = {64{4'h5}};
    localparam logic [LW-1:0] LINE_BEEF = {8{32'hDEADBEEF}};
    localparam logic [LW-1:0] WR_JUNK   = {8{32'hBAD0BAD0}};

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rd_line(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : {4{a}};
    endfunction

    // Monitor plus memory responder, all sampled on the falling edge.
    initial begin : mon
        mem_txn_t t;
        mem_txn_t cur;
        int       cnt;
        int       stray_seen;
        bit       busy;
        logic [LW-1:0] e;
        mem[64'h1000] = LINE_AA;
        mem[64'h4000] = LINE_BEEF;
        cnt = 0;
        stray_seen = 0;
        busy = 1'b0;
        cur = '{we: 1'b0, addr: '0, wdata: '0, cyc: 0};
        in_mem_valid = 1'b0;
        in_mem_rdata = '0;
        forever begin
            @(negedge clk);
            in_mem_valid = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                last_done = -100;
                stray_seen = stray_req;
            end else begin
                if (out_icache_valid) begin
                    if (exp_ic.size() == 0) chk("ic_valid_unexpected", LW'(1), LW'(0));
                    else begin
                        e = exp_ic.pop_front();
                        chk("ic_data", out_icache_data, e);
                        chk("ic_lat", LW'(cyc), LW'(last_done + 1));
                    end
                end
                if (out_data_valid) begin
                    if (exp_dt.size() == 0) chk("dt_valid_unexpected", LW'(1), LW'(0));
                    else begin
                        e = exp_dt.pop_front();
                        chk("dt_rdata", out_data_rdata, e);
                        chk("dt_lat", LW'(cyc), LW'(last_done + 1));
                    end
                end
                if (out_mem_req) begin
                    txn_cnt++;
                    if (exp_mem.size() == 0) chk("mem_req_unexpected", LW'(1), LW'(0));
                    else begin
                        t = exp_mem.pop_front();
                        chk("mem_we", LW'(out_mem_we), LW'(t.we));
                        chk("mem_addr", LW'(out_mem_addr), LW'(t.addr));
                        chk("mem_wdata", out_mem_wdata, t.wdata);
                        if (t.cyc >= 0) chk("mem_req_cycle", LW'(cyc), LW'(t.cyc));
                    end
                    chk("mem_gap", LW'((cyc - last_done) >= 2), LW'(1));
                    cur = '{we: out_mem_we, addr: out_mem_addr, wdata: out_mem_wdata, cyc: cyc};
                    busy = 1'b1;
                    cnt = mem_lat;
                end else if (busy) begin
                    cnt--;
                    if (cnt <= 0) begin
                        in_mem_valid = 1'b1;
                        in_mem_rdata = cur.we ? WR_JUNK : rd_line(cur.addr);
                        if (cur.we) mem[cur.addr] = cur.wdata;
                        busy = 1'b0;
                        last_done = cyc;
                    end
                end
                if (stray_req != stray_seen) begin
                    stray_seen = stray_req;
                    in_mem_valid = 1'b1;
                    in_mem_rdata = '1;
                end
            end
            rsp_busy = busy;
        end
    end

    // mode: 0 = no expectation, 1 = expected at any cycle, 2 = expected in the next cycle
    task automatic pulse_ic(input logic [AW-1:0] a, input int mode);
        @(negedge clk);
        if (mode != 0) begin
            exp_mem.push_back('{we: 1'b0, addr: a, wdata: '0, cyc: (mode == 2) ? cyc + 1 : -1});
            exp_ic.push_back(rd_line(a));
        end
        in_icache_req = 1'b1;
        in_icache_addr = a;
        @(negedge clk);
        in_icache_req = 1'b0;
    endtask

    task automatic pulse_dt(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        @(negedge clk);
        in_data_req = 1'b1;
        in_data_we = we;
        in_data_addr = a;
        in_data_wdata = wd;
        @(negedge clk);
        in_data_req = 1'b0;
    endtask

    task automatic wait_valid(input bit ic);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ic ? out_icache_valid : out_data_valid) return;
        end
        chk(ic ? "ic_wait_timeout" : "dt_wait_timeout", LW'(0), LW'(1));
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400; n++) begin
            if (exp_mem.size() == 0 && exp_ic.size() == 0 && exp_dt.size() == 0 && !rsp_busy) begin
                repeat (3) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("drain_timeout", LW'(exp_mem.size() + exp_ic.size() + exp_dt.size()), LW'(0));
        exp_mem.delete();
        exp_ic.delete();
        exp_dt.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_icache_req = 1'b0;
        in_data_req = 1'b0;
        in_data_we = 1'b0;
        #1;
        chk("rst_mem_req", LW'(out_mem_req), LW'(0));
        chk("rst_mem_addr", LW'(out_mem_addr), LW'(0));
        chk("rst_ic_valid", LW'(out_icache_valid), LW'(0));
        chk("rst_ic_data", out_icache_data, LW'(0));
        chk("rst_dt_valid", LW'(out_data_valid), LW'(0));
        chk("rst_dt_rdata", out_data_rdata, LW'(0));
        repeat (2) @(negedge clk);
        exp_mem.delete();
        exp_ic.delete();
        exp_dt.delete();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        logic [LW-1:0] w0;
        logic [LW-1:0] w2;
        w0 = {8{32'h0A0B0C0D}};
        w2 = {8{32'h11223344}};

        // single icache fill
        do_reset();
        mem_lat = 4;
        pulse_ic(64'h1000, 2);
        wait_drain();
        chk("s1_ic_line", out_icache_data, LINE_AA);

        // simultaneous icache read and data write: icache first, write ack leaves rdata alone
        do_reset();
        mem_lat = 3;
        @(negedge clk);
        exp_mem.push_back('{we: 1'b0, addr: 64'h2000, wdata: '0, cyc: cyc + 1});
        exp_mem.push_back('{we: 1'b1, addr: 64'h3000, wdata: LINE_55, cyc: -1});
        exp_ic.push_back(rd_line(64'h2000));
        exp_dt.push_back('0);
        in_icache_req = 1'b1;
        in_icache_addr = 64'h2000;
        in_data_req = 1'b1;
        in_data_we = 1'b1;
        in_data_addr = 64'h3000;
        in_data_wdata = LINE_55;
        @(negedge clk);
        in_icache_req = 1'b0;
        in_data_req = 1'b0;
        wait_drain();
        chk("s2_mem_written", mem.exists(64'h3000) ? mem[64'h3000] : '0, LINE_55);

        // round-robin under continuous load from both sides
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 4; i++) begin
            exp_mem.push_back('{we: 1'b0, addr: 64'h5000 + 64'(i * 64), wdata: '0, cyc: -1});
            exp_ic.push_back(rd_line(64'h5000 + 64'(i * 64)));
            exp_mem.push_back('{we: (i % 2 == 0), addr: (i < 2) ? 64'h6000 : 64'h6040,
                                wdata: (i == 0) ? w0 : ((i == 2) ? w2 : '0), cyc: -1});
        end
        exp_dt.push_back('0);
        exp_dt.push_back(w0);
        exp_dt.push_back(w0);
        exp_dt.push_back(w2);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    pulse_ic(64'h5000 + 64'(i * 64), 0);
                    wait_valid(1'b1);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    pulse_dt(j % 2 == 0, (j < 2) ? 64'h6000 : 64'h6040,
                             (j == 0) ? w0 : ((j == 2) ? w2 : '0));
                    wait_valid(1'b0);
                end
            end
        join
        wait_drain();

        // data read pulsed in the same cycle as the icache completion
        do_reset();
        mem_lat = 3;
        pulse_ic(64'h7000, 2);
        begin : find_valid
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                #1;
                if (in_mem_valid) disable find_valid;
            end
            chk("s4_mem_valid_timeout", LW'(0), LW'(1));
        end
        exp_mem.push_back('{we: 1'b0, addr: 64'h4000, wdata: '0, cyc: cyc + 2});
        exp_dt.push_back(rd_line(64'h4000));
        in_data_req = 1'b1;
        in_data_we = 1'b0;
        in_data_addr = 64'h4000;
        @(negedge clk);
        in_data_req = 1'b0;
        wait_drain();
        chk("s4_dt_line", out_data_rdata, LINE_BEEF);

        // reset in the middle of a wait, then a stray completion
        do_reset();
        mem_lat = 30;
        pulse_ic(64'h1000, 2);
        repeat (4) @(negedge clk);
        do_reset();
        c0 = txn_cnt;
        stray_req++;
        repeat (8) @(negedge clk);
        chk("s5_no_txn_after_stray", LW'(txn_cnt - c0), LW'(0));
        chk("s5_ic_data_clear", out_icache_data, LW'(0));
        mem_lat = 4;
        pulse_ic(64'h1000, 2);
        wait_drain();
        chk("s5_ic_line", out_icache_data, LINE_AA);

        // duplicate icache pulse while the first is in flight
        do_reset();
        mem_lat = 6;
        c0 = txn_cnt;
        pulse_ic(64'h8000, 1);
        repeat (2) @(negedge clk);
        pulse_ic(64'h9000, 0);
        wait_drain();
        repeat (10) @(negedge clk);
        chk("s6_one_txn", LW'(txn_cnt - c0), LW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
